// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WAIT_CNT_W = 8;

  // RUN: normal flow; DWAIT: data memory has held the pipeline for at least one cycle
  typedef enum logic {
    RUN   = 1'b0,
    DWAIT = 1'b1
  } hz_state_e;

  // True when the instruction in ID needs the destination of a load still in EX.
  // Register x0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic load_use_hit(
    input logic                  mem_read,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic [REG_ADDR_W-1:0] rs2,
    input logic                  use_rs1,
    input logic                  use_rs2
  );
    return mem_read && (rd != '0) &&
           ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of the hazard-controller signals exchanged with the pipeline datapath.
interface pipeline_hazard_ctrl_if
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_mem_read;
  logic                  ex_branch_taken;
  logic                  imem_ready;
  logic                  dmem_req;
  logic                  dmem_ready;

  logic                  pc_stall;
  logic                  if_id_stall;
  logic                  if_id_flush;
  logic                  id_ex_stall;
  logic                  id_ex_flush;
  logic                  ex_mem_stall;
  logic                  mem_wb_flush;
  logic                  mem_timeout;
  logic [CNT_W-1:0]      stall_cycles;

  // Datapath side: reports pipeline status, receives stall/flush controls
  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_rd_addr, ex_mem_read, ex_branch_taken,
           imem_ready, dmem_req, dmem_ready,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_flush, mem_timeout, stall_cycles
  );

  // Controller side
  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
           ex_rd_addr, ex_mem_read, ex_branch_taken,
           imem_ready, dmem_req, dmem_ready,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_flush, mem_timeout, stall_cycles
  );

endinterface

// File: rtl/stall_counter.sv
// Free-running performance counter of stalled cycles, wraps naturally.
module stall_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  // Count one per cycle with inc high; modulo 2^CNT_W wrap is intentional
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: data-memory freeze with timeout,
// taken-branch flush, load-use interlock and instruction-fetch bubbles.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  imem_ready,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_stall,
  output logic                  id_ex_flush,
  output logic                  ex_mem_stall,
  output logic                  mem_wb_flush,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LIM = WAIT_CNT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX    = '1;

  hz_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic abort;
  logic freeze;
  logic load_use;

  // The access is given up once it has waited MEM_TIMEOUT cycles in DWAIT,
  // which also releases the freeze in that same cycle.
  assign abort    = (state_q == DWAIT) && (wait_cnt_q == TIMEOUT_LIM);
  assign freeze   = dmem_req && !dmem_ready && !abort;
  assign load_use = load_use_hit(ex_mem_read, ex_rd_addr, id_rs1_addr,
                                 id_rs2_addr, id_uses_rs1, id_uses_rs2);

  // Next state: stay in DWAIT exactly while frozen; counter only runs in DWAIT
  always_comb begin
    state_d    = freeze ? DWAIT : RUN;
    wait_cnt_d = '0;
    if ((state_q == DWAIT) && freeze) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  // State and wait-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Prioritised control outputs: freeze > branch > load-use > fetch miss
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    mem_timeout  = 1'b0;
    if (!rst) begin
      if (freeze) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else begin
        // An aborted access must not be written back
        mem_wb_flush = abort;
        mem_timeout  = abort;
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
        end
      end
    end
  end

  stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_stall),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised + directed bench for pipeline_hazard_ctrl with a scoreboard.
module tb_pipeline_hazard_ctrl;
  import pipeline_pkg::*;

  localparam int TMO = 4;
  localparam int CW  = 8;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       im;
    logic       req;
    logic       rdy;
  } stim_t;

  // ctrl bits: 7 pc_stall, 6 if_id_stall, 5 if_id_flush, 4 id_ex_stall,
  //            3 id_ex_flush, 2 ex_mem_stall, 1 mem_wb_flush, 0 mem_timeout
  typedef struct {
    logic [7:0]    ctrl;
    logic [CW-1:0] cnt;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz_if ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (TMO),
    .CNT_W       (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1_addr     (hz_if.id_rs1_addr),
    .id_rs2_addr     (hz_if.id_rs2_addr),
    .id_uses_rs1     (hz_if.id_uses_rs1),
    .id_uses_rs2     (hz_if.id_uses_rs2),
    .ex_rd_addr      (hz_if.ex_rd_addr),
    .ex_mem_read     (hz_if.ex_mem_read),
    .ex_branch_taken (hz_if.ex_branch_taken),
    .imem_ready      (hz_if.imem_ready),
    .dmem_req        (hz_if.dmem_req),
    .dmem_ready      (hz_if.dmem_ready),
    .pc_stall        (hz_if.pc_stall),
    .if_id_stall     (hz_if.if_id_stall),
    .if_id_flush     (hz_if.if_id_flush),
    .id_ex_stall     (hz_if.id_ex_stall),
    .id_ex_flush     (hz_if.id_ex_flush),
    .ex_mem_stall    (hz_if.ex_mem_stall),
    .mem_wb_flush    (hz_if.mem_wb_flush),
    .mem_timeout     (hz_if.mem_timeout),
    .stall_cycles    (hz_if.stall_cycles)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  exp_t exp_q[$];

  // Reference model state: consecutive frozen cycles of the current access,
  // and the number of stalled cycles seen since reset.
  int          frozen_streak = 0;
  int unsigned stall_total   = 0;

  function automatic stim_t idle();
    stim_t s;
    s    = '0;
    s.im = 1'b1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    exp_t       e;
    logic       abort_m, freeze_m, lu_m;
    logic [7:0] c;
    @(posedge clk);
    #1;
    rst                   = s.rst;
    hz_if.id_rs1_addr     = s.rs1;
    hz_if.id_rs2_addr     = s.rs2;
    hz_if.id_uses_rs1     = s.u1;
    hz_if.id_uses_rs2     = s.u2;
    hz_if.ex_rd_addr      = s.rd;
    hz_if.ex_mem_read     = s.mr;
    hz_if.ex_branch_taken = s.br;
    hz_if.imem_ready      = s.im;
    hz_if.dmem_req        = s.req;
    hz_if.dmem_ready      = s.rdy;
    // An access is abandoned once it has been frozen for 1 + MEM_TIMEOUT cycles
    abort_m  = (frozen_streak == TMO + 1);
    freeze_m = s.req && !s.rdy && !abort_m;
    lu_m     = s.mr && (s.rd != 5'd0) &&
               ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    c = 8'b0;
    if (!s.rst) begin
      if (freeze_m) begin
        c = 8'b1101_0110;
      end else begin
        c[1] = abort_m;
        c[0] = abort_m;
        if (s.br)       begin c[5] = 1'b1; c[3] = 1'b1; end
        else if (lu_m)  begin c[7] = 1'b1; c[6] = 1'b1; c[3] = 1'b1; end
        else if (!s.im) begin c[7] = 1'b1; c[5] = 1'b1; end
      end
    end
    e.ctrl = c;
    e.cnt  = CW'(stall_total);
    e.cyc  = cyc;
    exp_q.push_back(e);
    if (s.rst) begin
      frozen_streak = 0;
      stall_total   = 0;
    end else begin
      frozen_streak = freeze_m ? frozen_streak + 1 : 0;
      stall_total   = (stall_total + c[7]) % (1 << CW);
    end
    cyc++;
  endtask

  // Monitor: outputs are combinational, so they are sampled mid-cycle
  exp_t       mon_e;
  logic [7:0] mon_got;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e   = exp_q.pop_front();
        mon_got = {hz_if.pc_stall, hz_if.if_id_stall, hz_if.if_id_flush,
                   hz_if.id_ex_stall, hz_if.id_ex_flush, hz_if.ex_mem_stall,
                   hz_if.mem_wb_flush, hz_if.mem_timeout};
        checks++;
        if (mon_got !== mon_e.ctrl) begin
          errors++;
          $display("FAIL ctrl cyc=%0d got=%b exp=%b", mon_e.cyc, mon_got, mon_e.ctrl);
        end else begin
          $display("cyc=%0d ctrl=%b cnt=%0d ok", mon_e.cyc, mon_got, hz_if.stall_cycles);
        end
        checks++;
        if (hz_if.stall_cycles !== mon_e.cnt) begin
          errors++;
          $display("FAIL stall_cycles cyc=%0d got=%0d exp=%0d",
                   mon_e.cyc, hz_if.stall_cycles, mon_e.cnt);
        end
      end
    end
  end

  initial begin
    stim_t s;
    int    rdy_pct;
    rst                   = 1'b1;
    hz_if.id_rs1_addr     = '0;
    hz_if.id_rs2_addr     = '0;
    hz_if.id_uses_rs1     = 1'b0;
    hz_if.id_uses_rs2     = 1'b0;
    hz_if.ex_rd_addr      = '0;
    hz_if.ex_mem_read     = 1'b0;
    hz_if.ex_branch_taken = 1'b0;
    hz_if.imem_ready      = 1'b1;
    hz_if.dmem_req        = 1'b0;
    hz_if.dmem_ready      = 1'b0;

    // Reset, with hazards present on the inputs to show outputs stay quiet
    s = idle(); s.rst = 1'b1; s.br = 1'b1; s.im = 1'b0;
    drive(s);
    drive(s);
    drive(idle());

    // Load x5 in EX, ID reads x5 as rs2: one-cycle interlock, then clear
    s = idle(); s.mr = 1'b1; s.rd = 5'd5; s.u2 = 1'b1; s.rs2 = 5'd5;
    s.u1 = 1'b1; s.rs1 = 5'd3;
    drive(s);
    drive(idle());

    // Load to x0 never interlocks
    s = idle(); s.mr = 1'b1; s.rd = 5'd0; s.u1 = 1'b1; s.rs1 = 5'd0;
    s.u2 = 1'b1; s.rs2 = 5'd0;
    drive(s);

    // Data memory slow for 3 cycles, completes on the 4th
    s = idle(); s.req = 1'b1;
    repeat (3) drive(s);
    s.rdy = 1'b1;
    drive(s);
    drive(idle());

    // Ready in the very first cycle: no freeze
    s = idle(); s.req = 1'b1; s.rdy = 1'b1;
    drive(s);

    // Never ready: 1 + TMO frozen cycles, then the timeout pulse
    s = idle(); s.req = 1'b1;
    repeat (TMO + 2) drive(s);
    drive(idle());

    // Branch beats load-use and fetch miss
    s = idle(); s.br = 1'b1; s.im = 1'b0; s.mr = 1'b1; s.rd = 5'd7;
    s.u1 = 1'b1; s.rs1 = 5'd7;
    drive(s);
    // Same, but under freeze; the flush shows up on the release cycle
    s.req = 1'b1;
    drive(s);
    drive(s);
    s.rdy = 1'b1;
    drive(s);

    // Request dropped mid-wait returns to RUN
    s = idle(); s.req = 1'b1;
    drive(s);
    drive(s);
    drive(idle());

    // Reset in the second DWAIT cycle: silent abort
    s = idle(); s.req = 1'b1;
    drive(s);
    drive(s);
    s.rst = 1'b1;
    drive(s);
    drive(idle());

    // Randomised traffic; small register range to provoke matches
    rdy_pct = 50;
    for (int i = 0; i < 1500; i++) begin
      if ((i % 32) == 0) begin
        case ($urandom_range(0, 2))
          0: rdy_pct = 5;
          1: rdy_pct = 40;
          default: rdy_pct = 90;
        endcase
      end
      s      = idle();
      s.rst  = ($urandom_range(0, 199) == 0);
      s.rs1  = 5'($urandom_range(0, 3));
      s.rs2  = 5'($urandom_range(0, 3));
      s.rd   = 5'($urandom_range(0, 3));
      s.u1   = 1'($urandom_range(0, 1));
      s.u2   = 1'($urandom_range(0, 1));
      s.mr   = 1'($urandom_range(0, 1));
      s.br   = ($urandom_range(0, 7) == 0);
      s.im   = ($urandom_range(0, 9) < 8);
      s.req  = ($urandom_range(0, 9) < 7);
      s.rdy  = ($urandom_range(0, 99) < rdy_pct);
      drive(s);
    end

    // Let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, max consecutive data-memory wait cycles before abort (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 32, width of stall-cycle performance counter.
REQ-003 SHALL have ports, one clock; reset is synchronous and active-high:
  clk  input  1  clock, all state on rising edge
  rst  input  1  synchronous active-high reset
  id_rs1_addr  input  5  rs1 of instruction in ID
  id_rs2_addr  input  5  rs2 of instruction in ID
  id_uses_rs1  input  1  ID instruction reads rs1
  id_uses_rs2  input  1  ID instruction reads rs2
  ex_rd_addr  input  5  rd of instruction in EX
  ex_mem_read  input  1  EX instruction is a load
  ex_branch_taken  input  1  EX resolved taken branch/jump
  imem_ready  input  1  instruction fetch data valid this cycle
  dmem_req  input  1  MEM stage issuing load/store
  dmem_ready  input  1  data memory completes access this cycle
  pc_stall  output  1  hold PC
  if_id_stall  output  1  hold IF/ID
  if_id_flush  output  1  load bubble into IF/ID
  id_ex_stall  output  1  hold ID/EX
  id_ex_flush  output  1  load bubble into ID/EX
  ex_mem_stall  output  1  hold EX/MEM
  mem_wb_flush  output  1  load bubble into MEM/WB
  mem_timeout  output  1  one-cycle pulse, data access aborted
  stall_cycles  output  CNT_W  count of cycles with pc_stall=1

Function
REQ-004 SHALL implement FSM with states RUN and DWAIT plus 8-bit wait counter wait_cnt.
REQ-005 freeze SHALL be (dmem_req && !dmem_ready && !abort), where abort = (state==DWAIT && wait_cnt==MEM_TIMEOUT).
REQ-006 freeze=1 SHALL drive pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_flush =1 and all other flushes =0 (highest priority).
REQ-007 Else ex_branch_taken=1 SHALL drive if_id_flush=1, id_ex_flush=1, no stalls; branch suppressed while frozen takes effect first unfrozen cycle.
REQ-008 Else load-use (ex_mem_read && ex_rd_addr!=0 && ((id_uses_rs1 && id_rs1_addr==ex_rd_addr) || (id_uses_rs2 && id_rs2_addr==ex_rd_addr))) SHALL drive pc_stall, if_id_stall, id_ex_flush =1 for exactly that cycle.
REQ-009 Else imem_ready=0 SHALL drive pc_stall=1, if_id_flush=1.
REQ-010 Otherwise all stall/flush outputs SHALL be 0; all control outputs combinational from inputs and state (zero latency).
REQ-011 RUN->DWAIT when freeze=1; DWAIT->RUN when dmem_ready=1 or abort; DWAIT holds otherwise.
REQ-012 wait_cnt SHALL clear in RUN and on exit, increment each DWAIT cycle, never wrap.
REQ-013 On abort cycle: freeze=0, mem_timeout=1, mem_wb_flush=1 (aborted access not written back), pipeline otherwise advances per REQ-007..010.
REQ-014 dmem_ready=1 on the same cycle as entry SHALL not enter DWAIT; dmem_req dropping in DWAIT SHALL return to RUN.
REQ-015 stall_cycles SHALL increment by 1 each cycle pc_stall=1, wrap modulo 2^CNT_W.

Reset
REQ-016 rst=1 SHALL set state=RUN, wait_cnt=0, stall_cycles=0.
REQ-017 While rst=1 all stall/flush outputs and mem_timeout SHALL be 0; reset mid-DWAIT aborts the wait silently (no mem_timeout pulse).

Structure
REQ-018 State enum (RUN, DWAIT) and REG_ADDR_W=5 SHALL live in shared package pipeline_pkg.
REQ-019 Performance counter SHALL be sub-module stall_counter (clk, rst, inc, count); remaining logic inline.

Verification
REQ-020 Load x5 in EX, ID add reads rs2=x5 -> one cycle pc_stall=1, if_id_stall=1, id_ex_flush=1; next cycle all 0.
REQ-021 Load rd=x0, ID reads x0 -> no stall; stall_cycles unchanged.
REQ-022 dmem_req=1, dmem_ready low 3 cycles then high -> freeze 3 cycles, state DWAIT, release on 4th cycle, stall_cycles +3.
REQ-023 MEM_TIMEOUT=4, dmem_ready never asserted -> freeze 1+4 cycles, then mem_timeout pulse 1 cycle with mem_wb_flush=1, state RUN.
REQ-024 ex_branch_taken=1 coincident with load-use and imem_ready=0 -> only if_id_flush=1, id_ex_flush=1; with freeze also active -> freeze outputs only, flush on release cycle.
REQ-025 rst asserted in DWAIT cycle 2 -> outputs 0 same cycle, state RUN, stall_cycles=0 next cycle, no mem_timeout.
